cc_reorder_issue_ctrl: RTL and testbench

Issue-side sequencer for the cache controller's read-data reorder path. It accepts one tag-lookup result per handshake and writes a program-order hit flag for every request. For a hit, it pushes the line plus offset into the hit-data buffer. For a miss, it issues a single 8-beat AXI AR burst to memory. It bounds outstanding misses and applies back-pressure to lookup from the reorder unit's almost-full flags and from AR stalls.

---
 rtl/cc_reorder_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_cc_reorder_issue_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_reorder_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cc_reorder_issue_ctrl
// Brief    : Issue-side sequencer for the read-data reorder path. It writes
//            program-order hit flags, pushes hit data and issues miss bursts.
// Revision : 1.0 - initial release
// ============================================================================
module cc_reorder_issue_ctrl #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  lookup_valid_i,
    output logic                  lookup_ready_o,
    input  logic                  lookup_hit_i,
    input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
    input  logic [511:0]          lookup_line_i,

    input  logic                  hit_flag_fifo_afull_i,
    output logic                  hit_flag_fifo_wren_o,
    output logic                  hit_flag_fifo_wdata_o,

    input  logic                  hit_data_fifo_afull_i,
    output logic                  hit_data_fifo_wren_o,
    output logic [517:0]          hit_data_fifo_wdata_o,

    output logic [ADDR_WIDTH-1:0] mem_araddr_o,
    output logic [3:0]            mem_arlen_o,
    output logic [1:0]            mem_arburst_o,
    output logic                  mem_arvalid_o,
    input  logic                  mem_arready_i,

    input  logic                  mem_rvalid_i,
    input  logic                  mem_rready_i,
    input  logic                  mem_rlast_i
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_AR_REQ = 1'b1
    } state_t;

    localparam logic [2:0] c_MAX_OUT   = 3'(MAX_OUTSTANDING);
    localparam logic [3:0] c_ARLEN     = 4'd7;
    localparam logic [1:0] c_BURST_WRP = 2'b10;

    state_t                r_state;
    logic [2:0]            r_count;
    logic                  r_flag_wren;
    logic                  r_flag_wdata;
    logic                  r_data_wren;
    logic [517:0]          r_data_wdata;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [3:0]            r_arlen;
    logic [1:0]            r_arburst;
    logic                  r_arvalid;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_accept_hit;
    logic                  w_accept_miss;
    logic                  w_rdone;

    // Ready is held low while reset is asserted even though the state is IDLE.
    always_comb begin
        w_ready = 1'b0;
        if (rst_n && (r_state == S_IDLE) && !hit_flag_fifo_afull_i) begin
            if (lookup_hit_i)
                w_ready = !hit_data_fifo_afull_i;
            else
                w_ready = (r_count < c_MAX_OUT);
        end
    end

    assign w_accept      = lookup_valid_i && w_ready;
    assign w_accept_hit  = w_accept && lookup_hit_i;
    assign w_accept_miss = w_accept && !lookup_hit_i;
    assign w_rdone       = mem_rvalid_i && mem_rready_i && mem_rlast_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_count      <= 3'd0;
            r_flag_wren  <= 1'b0;
            r_flag_wdata <= 1'b0;
            r_data_wren  <= 1'b0;
            r_data_wdata <= '0;
            r_araddr     <= '0;
            r_arlen      <= 4'd0;
            r_arburst    <= 2'b00;
            r_arvalid    <= 1'b0;
        end else begin
            r_flag_wren  <= w_accept;
            r_flag_wdata <= w_accept_hit;
            r_data_wren  <= w_accept_hit;
            if (w_accept_hit)
                r_data_wdata <= {lookup_addr_i[5:0], lookup_line_i};

            // A completion arriving at zero is dropped so the count cannot wrap.
            if (w_accept_miss && !w_rdone)
                r_count <= r_count + 3'd1;
            else if (w_rdone && !w_accept_miss && (r_count != 3'd0))
                r_count <= r_count - 3'd1;

            case (r_state)
                S_IDLE: begin
                    if (w_accept_miss) begin
                        r_state   <= S_AR_REQ;
                        r_arvalid <= 1'b1;
                        r_araddr  <= {lookup_addr_i[ADDR_WIDTH-1:3], 3'b000};
                        r_arlen   <= c_ARLEN;
                        r_arburst <= c_BURST_WRP;
                    end
                end
                S_AR_REQ: begin
                    if (mem_arready_i) begin
                        r_state   <= S_IDLE;
                        r_arvalid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_arvalid <= 1'b0;
                end
            endcase
        end
    end

    assign lookup_ready_o        = w_ready;
    assign hit_flag_fifo_wren_o  = r_flag_wren;
    assign hit_flag_fifo_wdata_o = r_flag_wdata;
    assign hit_data_fifo_wren_o  = r_data_wren;
    assign hit_data_fifo_wdata_o = r_data_wdata;
    assign mem_araddr_o          = r_araddr;
    assign mem_arlen_o           = r_arlen;
    assign mem_arburst_o         = r_arburst;
    assign mem_arvalid_o         = r_arvalid;

endmodule
`default_nettype wire

// File: tb/tb_cc_reorder_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cc_reorder_issue_ctrl
// Brief    : Directed vector bench for cc_reorder_issue_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cc_reorder_issue_ctrl;

    logic         clk;
    logic         rst_n;
    logic         lookup_valid_i;
    logic         lookup_ready_o;
    logic         lookup_hit_i;
    logic [31:0]  lookup_addr_i;
    logic [511:0] lookup_line_i;
    logic         hit_flag_fifo_afull_i;
    logic         hit_flag_fifo_wren_o;
    logic         hit_flag_fifo_wdata_o;
    logic         hit_data_fifo_afull_i;
    logic         hit_data_fifo_wren_o;
    logic [517:0] hit_data_fifo_wdata_o;
    logic [31:0]  mem_araddr_o;
    logic [3:0]   mem_arlen_o;
    logic [1:0]   mem_arburst_o;
    logic         mem_arvalid_o;
    logic         mem_arready_i;
    logic         mem_rvalid_i;
    logic         mem_rready_i;
    logic         mem_rlast_i;

    cc_reorder_issue_ctrl #(.MAX_OUTSTANDING(4), .ADDR_WIDTH(32)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .lookup_valid_i        (lookup_valid_i),
        .lookup_ready_o        (lookup_ready_o),
        .lookup_hit_i          (lookup_hit_i),
        .lookup_addr_i         (lookup_addr_i),
        .lookup_line_i         (lookup_line_i),
        .hit_flag_fifo_afull_i (hit_flag_fifo_afull_i),
        .hit_flag_fifo_wren_o  (hit_flag_fifo_wren_o),
        .hit_flag_fifo_wdata_o (hit_flag_fifo_wdata_o),
        .hit_data_fifo_afull_i (hit_data_fifo_afull_i),
        .hit_data_fifo_wren_o  (hit_data_fifo_wren_o),
        .hit_data_fifo_wdata_o (hit_data_fifo_wdata_o),
        .mem_araddr_o          (mem_araddr_o),
        .mem_arlen_o           (mem_arlen_o),
        .mem_arburst_o         (mem_arburst_o),
        .mem_arvalid_o         (mem_arvalid_o),
        .mem_arready_i         (mem_arready_i),
        .mem_rvalid_i          (mem_rvalid_i),
        .mem_rready_i          (mem_rready_i),
        .mem_rlast_i           (mem_rlast_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        h;
        logic [31:0] a;
        logic        ffa;
        logic        dfa;
        logic        ary;
        logic        rl;
        logic        e_rdy;
        logic        e_fw;
        logic        e_fd;
        logic        e_dw;
        logic        e_arv;
        logic [31:0] e_ara;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    function automatic vec_t mk(input logic v, input logic h, input logic [31:0] a,
                                input logic ffa, input logic dfa, input logic ary,
                                input logic rl, input logic e_rdy, input logic e_fw,
                                input logic e_fd, input logic e_dw, input logic e_arv,
                                input logic [31:0] e_ara);
        vec_t t;
        t.v = v; t.h = h; t.a = a; t.ffa = ffa; t.dfa = dfa; t.ary = ary; t.rl = rl;
        t.e_rdy = e_rdy; t.e_fw = e_fw; t.e_fd = e_fd; t.e_dw = e_dw;
        t.e_arv = e_arv; t.e_ara = e_ara;
        return t;
    endfunction

    function automatic logic [511:0] line_of(input logic [31:0] a);
        return {16{a ^ 32'hA5A5_0000}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic h, input logic [31:0] a,
                         input logic ffa, input logic dfa, input logic ary, input logic rl);
        lookup_valid_i        = v;
        lookup_hit_i          = h;
        lookup_addr_i         = a;
        lookup_line_i         = line_of(a);
        hit_flag_fifo_afull_i = ffa;
        hit_data_fifo_afull_i = dfa;
        mem_arready_i         = ary;
        mem_rvalid_i          = rl;
        mem_rready_i          = rl;
        mem_rlast_i           = rl;
    endtask

    task automatic check_outputs(input string tag, input vec_t t);
        chk({tag, ".flag_wren"}, 32'(hit_flag_fifo_wren_o), 32'(t.e_fw));
        if (t.e_fw)
            chk({tag, ".flag_wdata"}, 32'(hit_flag_fifo_wdata_o), 32'(t.e_fd));
        chk({tag, ".data_wren"}, 32'(hit_data_fifo_wren_o), 32'(t.e_dw));
        if (t.e_dw) begin
            chk({tag, ".data_offset"}, 32'(hit_data_fifo_wdata_o[517:512]), 32'(t.a[5:0]));
            n_checks++;
            if (hit_data_fifo_wdata_o[511:0] !== line_of(t.a)) begin
                n_fail++;
                $display("FAIL %s.data_line: got 0x%0h expected 0x%0h", tag,
                         hit_data_fifo_wdata_o[31:0], line_of(t.a) & 512'hFFFF_FFFF);
            end
        end
        chk({tag, ".arvalid"}, 32'(mem_arvalid_o), 32'(t.e_arv));
        if (t.e_arv) begin
            chk({tag, ".araddr"}, mem_araddr_o, t.e_ara);
            chk({tag, ".arlen"}, 32'(mem_arlen_o), 32'd7);
            chk({tag, ".arburst"}, 32'(mem_arburst_o), 32'd2);
        end
    endtask

    // One accepted miss with immediate arready: accept cycle then AR cycle.
    task automatic miss_ok(input string tag, input logic [31:0] a);
        vec_t t;
        @(negedge clk);
        drive(1'b1, 1'b0, a, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 chk({tag, ".ready"}, 32'(lookup_ready_o), 32'd1);
        @(posedge clk);
        #1;
        t = mk(1, 0, a, 0, 0, 1, 0, 1, 1, 0, 0, 1, {a[31:3], 3'b000});
        check_outputs(tag, t);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1 chk({tag, ".ar_done"}, 32'(mem_arvalid_o), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ready",     32'(lookup_ready_o), 32'd0);
        chk("reset.flag_wren", 32'(hit_flag_fifo_wren_o), 32'd0);
        chk("reset.data_wren", 32'(hit_data_fifo_wren_o), 32'd0);
        chk("reset.arvalid",   32'(mem_arvalid_o), 32'd0);
        chk("reset.araddr",    mem_araddr_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //              v  h  addr          ffa dfa ary rl rdy fw fd dw arv araddr
        vecs.push_back(mk(1, 1, 32'h40,        0, 0, 1, 0,  1, 1, 1, 1, 0, 32'h0));
        vecs.push_back(mk(1, 1, 32'h48,        0, 0, 1, 0,  1, 1, 1, 1, 0, 32'h0));
        vecs.push_back(mk(1, 1, 32'h7F,        0, 0, 1, 0,  1, 1, 1, 1, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 0,  1, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h1234_5678, 0, 0, 0, 0,  1, 1, 0, 0, 1, 32'h1234_5678));
        vecs.push_back(mk(1, 1, 32'h80,        0, 0, 0, 0,  0, 0, 0, 0, 1, 32'h1234_5678));
        vecs.push_back(mk(1, 1, 32'h80,        0, 0, 0, 0,  0, 0, 0, 0, 1, 32'h1234_5678));
        vecs.push_back(mk(1, 1, 32'h80,        0, 0, 0, 0,  0, 0, 0, 0, 1, 32'h1234_5678));
        vecs.push_back(mk(1, 1, 32'h80,        0, 0, 1, 0,  0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 32'h80,        0, 0, 0, 0,  1, 1, 1, 1, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 1,  1, 0, 0, 0, 0, 32'h0));
        // Fill the outstanding window with four misses, fifth stalls.
        vecs.push_back(mk(1, 0, 32'h100,       0, 0, 1, 0,  1, 1, 0, 0, 1, 32'h100));
        vecs.push_back(mk(1, 0, 32'h200,       0, 0, 1, 0,  0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h200,       0, 0, 1, 0,  1, 1, 0, 0, 1, 32'h200));
        vecs.push_back(mk(1, 0, 32'h300,       0, 0, 1, 0,  0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h300,       0, 0, 1, 0,  1, 1, 0, 0, 1, 32'h300));
        vecs.push_back(mk(1, 0, 32'h400,       0, 0, 1, 0,  0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h400,       0, 0, 1, 0,  1, 1, 0, 0, 1, 32'h400));
        vecs.push_back(mk(1, 0, 32'h500,       0, 0, 1, 0,  0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h500,       0, 0, 1, 0,  0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h500,       0, 0, 1, 1,  0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h500,       0, 0, 1, 0,  1, 1, 0, 0, 1, 32'h500));
        vecs.push_back(mk(1, 0, 32'h50F,       0, 0, 1, 0,  0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 32'hC3,        0, 0, 1, 0,  1, 1, 1, 1, 0, 32'h0));
        // Miss accepted together with a completion at count 3.
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 1,  0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h60F,       0, 0, 1, 1,  1, 1, 0, 0, 1, 32'h608));
        vecs.push_back(mk(1, 0, 32'h700,       0, 0, 1, 0,  0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h700,       0, 0, 1, 0,  1, 1, 0, 0, 1, 32'h700));
        vecs.push_back(mk(1, 0, 32'h800,       0, 0, 1, 0,  0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h800,       0, 0, 1, 0,  0, 0, 0, 0, 0, 32'h0));
        // Almost-full back-pressure.
        vecs.push_back(mk(1, 1, 32'h900,       0, 1, 1, 0,  0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 1, 1, 1,  0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h900,       0, 1, 1, 0,  1, 1, 0, 0, 1, 32'h900));
        vecs.push_back(mk(1, 1, 32'h940,       0, 1, 1, 0,  0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 32'h940,       1, 0, 1, 0,  0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'hA00,       1, 0, 1, 1,  0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'hA00,       1, 0, 1, 0,  0, 0, 0, 0, 0, 32'h0));
        // Drain to zero, then a stray completion must not wrap the count.
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 1,  1, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 1,  1, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 1,  1, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 1,  1, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 0,  1, 0, 0, 0, 0, 32'h0));

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            @(negedge clk);
            drive(vecs[i].v, vecs[i].h, vecs[i].a, vecs[i].ffa, vecs[i].dfa,
                  vecs[i].ary, vecs[i].rl);
            #1 chk({tag, ".ready"}, 32'(lookup_ready_o), 32'(vecs[i].e_rdy));
            @(posedge clk);
            #1 check_outputs(tag, vecs[i]);
        end

        // Count is 0 here: fill to 4 with the last AR stalled, then reset mid-AR.
        miss_ok("pre0", 32'hB00);
        miss_ok("pre1", 32'hB40);
        miss_ok("pre2", 32'hB80);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'hBC0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 chk("pre3.arvalid", 32'(mem_arvalid_o), 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.arvalid", 32'(mem_arvalid_o), 32'd0);
        chk("midrst.araddr",  mem_araddr_o, 32'd0);
        chk("midrst.ready",   32'(lookup_ready_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Cleared count admits four fresh misses before stalling the fifth.
        miss_ok("post0", 32'hC00);
        miss_ok("post1", 32'hC40);
        miss_ok("post2", 32'hC80);
        miss_ok("post3", 32'hCC0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'hD00, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 chk("post4.ready", 32'(lookup_ready_o), 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b1, 32'hD25, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 chk("posthit.ready", 32'(lookup_ready_o), 32'd1);
        @(posedge clk);
        #1 check_outputs("posthit", mk(1, 1, 32'hD25, 0, 0, 1, 0, 1, 1, 1, 1, 0, 32'h0));
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
